// File: rtl/eth_rx_ctrl_pkg.sv
// eth_rx_ctrl_pkg
// Shared definitions for the GMII/MII receive-path controller:
//   - link speed encodings as carried on cfg_speed / active_speed
//   - controller state enumeration
//   - helper that maps a speed code to the receiver nibble-mode select
package eth_rx_ctrl_pkg;

    localparam logic [1:0] SPEED_10   = 2'd0;
    localparam logic [1:0] SPEED_100  = 2'd1;
    localparam logic [1:0] SPEED_1000 = 2'd2;
    localparam logic [1:0] SPEED_RSVD = 2'd3;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SWITCH   = 2'd1,
        IDLE     = 2'd2,
        BUSY     = 2'd3
    } rx_state_e;

    // 10M and 100M both run the receiver in nibble (MII) mode.
    function automatic logic speed_is_mii(input logic [1:0] speed);
        return (speed != SPEED_1000);
    endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// eth_stat_counter
// Saturating statistics counter.
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   count one event this cycle
//   clr    in   clear; an event in the same cycle leaves the count at 1
//   count  out  current count, sticks at all-ones
module eth_stat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eth_rx_ctrl.sv
// eth_rx_ctrl
// Receive-path controller sitting between the MAC configuration registers
// and the GMII/MII frame receiver. Applies speed / enable changes only
// between frames, holds the receiver in reset around each reconfiguration,
// generates the receiver clock enable and keeps saturating statistics.
//
// Ports:
//   clk, rst_n                     core clock, async active-low reset
//   cfg_rx_enable, cfg_speed       requested enable / link speed (3 = keep)
//   stat_clear                     one-cycle pulse, clears all statistics
//   gmii_rx_dv                     raw GMII data valid
//   rx_tvalid, rx_tlast, rx_tuser  receiver AXI-stream output
//   rx_error_bad_fcs               receiver FCS-error pulse
//   rx_rst                         active-high receiver reset
//   clk_enable, mii_select         receiver clock enable / nibble mode
//   active_speed                   speed currently applied
//   rx_busy                        a frame is in progress
//   stat_*                         saturating statistics counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISABLED | receiver held in reset, waiting for cfg_rx_enable
// SWITCH   | receiver held in reset RST_CYCLES cycles; speed loaded last
// IDLE     | between frames; config changes are accepted here
// BUSY     | frame in progress; waits for IFG_MIN quiet ticks
import eth_rx_ctrl_pkg::*;

module eth_rx_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int DIV_100    = 5,
    parameter int DIV_10     = 50,
    parameter int IFG_MIN    = 12,
    parameter int RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_rx_enable,
    input  logic [1:0]           cfg_speed,
    input  logic                 stat_clear,
    input  logic                 gmii_rx_dv,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    input  logic                 rx_tuser,
    input  logic                 rx_error_bad_fcs,
    output logic                 rx_rst,
    output logic                 clk_enable,
    output logic                 mii_select,
    output logic [1:0]           active_speed,
    output logic                 rx_busy,
    output logic [CNT_WIDTH-1:0] stat_bytes,
    output logic [CNT_WIDTH-1:0] stat_frames_good,
    output logic [CNT_WIDTH-1:0] stat_frames_bad,
    output logic [CNT_WIDTH-1:0] stat_fcs_err
);

    localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int IDLE_W  = $clog2(IFG_MIN + 1);

    localparam logic [DIV_W-1:0]  DIV_100_LOAD = DIV_W'(DIV_100 - 1);
    localparam logic [DIV_W-1:0]  DIV_10_LOAD  = DIV_W'(DIV_10 - 1);
    localparam logic [RST_W-1:0]  RST_LOAD     = RST_W'(RST_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IFG_LIMIT    = IDLE_W'(IFG_MIN);

    rx_state_e         state_q;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [DIV_W-1:0]  div_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_d;
    logic [1:0]        active_speed_q;
    logic              mii_select_q;
    logic              rx_rst_q;
    logic              rx_busy_q;

    logic              run;
    logic              tick;
    logic [DIV_W-1:0]  div_load;

    // The tick divider is a down-counter: the enable fires when it sits at
    // zero, so the first IDLE cycle after SWITCH (counter cleared) is a tick.
    always_comb begin
        run      = (state_q == IDLE) || (state_q == BUSY);
        tick     = run && ((active_speed_q == SPEED_1000) || (div_cnt_q == '0));
        div_load = (active_speed_q == SPEED_10) ? DIV_10_LOAD : DIV_100_LOAD;

        div_cnt_d = div_cnt_q;
        if (run && (active_speed_q != SPEED_1000)) begin
            div_cnt_d = (div_cnt_q == '0) ? div_load : div_cnt_q - 1'b1;
        end

        // Any line activity restarts the inter-frame gap measurement.
        idle_cnt_d = idle_cnt_q;
        if (gmii_rx_dv || rx_tvalid) begin
            idle_cnt_d = '0;
        end else if (tick && (idle_cnt_q != IFG_LIMIT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= DISABLED;
            rst_cnt_q      <= '0;
            div_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            active_speed_q <= SPEED_1000;
            mii_select_q   <= 1'b0;
            rx_rst_q       <= 1'b1;
            rx_busy_q      <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idle_cnt_q <= idle_cnt_d;

            case (state_q)
                DISABLED: begin
                    if (cfg_rx_enable) begin
                        state_q   <= SWITCH;
                        rst_cnt_q <= RST_LOAD;
                    end
                end

                SWITCH: begin
                    if (rst_cnt_q == '0) begin
                        // Reserved speed code keeps whatever was applied last.
                        if (cfg_speed != SPEED_RSVD) begin
                            active_speed_q <= cfg_speed;
                            mii_select_q   <= speed_is_mii(cfg_speed);
                        end
                        div_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                        rx_rst_q   <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end

                IDLE: begin
                    // Frame start has priority so a frame is never cut by a
                    // reconfiguration requested in the same cycle.
                    if (gmii_rx_dv) begin
                        rx_busy_q <= 1'b1;
                        state_q   <= BUSY;
                    end else if (!cfg_rx_enable) begin
                        rx_rst_q <= 1'b1;
                        state_q  <= DISABLED;
                    end else if ((cfg_speed != SPEED_RSVD) &&
                                 (cfg_speed != active_speed_q)) begin
                        rx_rst_q  <= 1'b1;
                        rst_cnt_q <= RST_LOAD;
                        state_q   <= SWITCH;
                    end
                end

                BUSY: begin
                    if (idle_cnt_q == IFG_LIMIT) begin
                        rx_busy_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                default: begin
                    rx_rst_q  <= 1'b1;
                    rx_busy_q <= 1'b0;
                    state_q   <= DISABLED;
                end
            endcase
        end
    end

    assign rx_rst       = rx_rst_q;
    assign clk_enable   = tick;
    assign mii_select   = mii_select_q;
    assign active_speed = active_speed_q;
    assign rx_busy      = rx_busy_q;

    logic ev_byte;
    logic ev_good;
    logic ev_bad;

    assign ev_byte = rx_tvalid;
    assign ev_good = rx_tvalid & rx_tlast & ~rx_tuser;
    assign ev_bad  = rx_tvalid & rx_tlast &  rx_tuser;

    eth_stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_bytes (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_byte),
        .clr   (stat_clear),
        .count (stat_bytes)
    );

    eth_stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_good (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_good),
        .clr   (stat_clear),
        .count (stat_frames_good)
    );

    eth_stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_bad (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_bad),
        .clr   (stat_clear),
        .count (stat_frames_bad)
    );

    eth_stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_fcs (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rx_error_bad_fcs),
        .clr   (stat_clear),
        .count (stat_fcs_err)
    );

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed self-checking bench for eth_rx_ctrl. Two instances share all
// inputs: one with 32-bit counters, one with 4-bit counters for saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_eth_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_rx_enable = 1'b0;
    logic [1:0]  cfg_speed = 2'd2;
    logic        stat_clear = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic        rx_tuser = 1'b0;
    logic        rx_error_bad_fcs = 1'b0;

    logic        rx_rst, clk_enable, mii_select, rx_busy;
    logic [1:0]  active_speed;
    logic [31:0] stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err;

    logic        rx_rst_s, clk_enable_s, mii_select_s, rx_busy_s;
    logic [1:0]  active_speed_s;
    logic [3:0]  stat_bytes_s, stat_frames_good_s, stat_frames_bad_s, stat_fcs_err_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eth_rx_ctrl #(.CNT_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_rx_enable    (cfg_rx_enable),
        .cfg_speed        (cfg_speed),
        .stat_clear       (stat_clear),
        .gmii_rx_dv       (gmii_rx_dv),
        .rx_tvalid        (rx_tvalid),
        .rx_tlast         (rx_tlast),
        .rx_tuser         (rx_tuser),
        .rx_error_bad_fcs (rx_error_bad_fcs),
        .rx_rst           (rx_rst),
        .clk_enable       (clk_enable),
        .mii_select       (mii_select),
        .active_speed     (active_speed),
        .rx_busy          (rx_busy),
        .stat_bytes       (stat_bytes),
        .stat_frames_good (stat_frames_good),
        .stat_frames_bad  (stat_frames_bad),
        .stat_fcs_err     (stat_fcs_err)
    );

    eth_rx_ctrl #(.CNT_WIDTH(4)) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_rx_enable    (cfg_rx_enable),
        .cfg_speed        (cfg_speed),
        .stat_clear       (stat_clear),
        .gmii_rx_dv       (gmii_rx_dv),
        .rx_tvalid        (rx_tvalid),
        .rx_tlast         (rx_tlast),
        .rx_tuser         (rx_tuser),
        .rx_error_bad_fcs (rx_error_bad_fcs),
        .rx_rst           (rx_rst_s),
        .clk_enable       (clk_enable_s),
        .mii_select       (mii_select_s),
        .active_speed     (active_speed_s),
        .rx_busy          (rx_busy_s),
        .stat_bytes       (stat_bytes_s),
        .stat_frames_good (stat_frames_good_s),
        .stat_frames_bad  (stat_frames_bad_s),
        .stat_fcs_err     (stat_fcs_err_s)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // {rx_rst, clk_enable, mii_select, active_speed, rx_busy} at reset
    localparam logic [5:0] CTRL_RESET = 6'b1_0_0_10_0;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({rx_rst, clk_enable, mii_select, active_speed, rx_busy} !== CTRL_RESET) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {rx_rst, clk_enable, mii_select, active_speed, rx_busy}, CTRL_RESET);
        end
        checks++;
        if ({stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err} !== 128'd0) begin
            failures++;
            $display("FAIL reset_stats got=%h %h %h %h exp=0",
                     stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err);
        end
    endtask

    task automatic test_bringup_1000();
        logic [9:0] rst_v, ce_v;
        cfg_rx_enable = 1'b1;
        cfg_speed     = 2'd2;
        rst_n         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            rst_v[i] = rx_rst;
            ce_v[i]  = clk_enable;
        end
        checks++;
        if (rst_v !== 10'b00_0000_1111) begin
            failures++;
            $display("FAIL bringup_rx_rst got=%b exp=%b", rst_v, 10'b00_0000_1111);
        end
        checks++;
        if (ce_v !== 10'b11_1111_0000) begin
            failures++;
            $display("FAIL bringup_clk_enable got=%b exp=%b", ce_v, 10'b11_1111_0000);
        end
        checks++;
        if ({mii_select, active_speed} !== 3'b0_10) begin
            failures++;
            $display("FAIL bringup_speed got=%b exp=%b", {mii_select, active_speed}, 3'b0_10);
        end
    endtask

    task automatic test_speed_100();
        logic [23:0] rst_v, ce_v;
        cfg_speed = 2'd1;
        for (int i = 0; i < 24; i++) begin
            step();
            rst_v[i] = rx_rst;
            ce_v[i]  = clk_enable;
        end
        checks++;
        if (rst_v !== 24'h00000F) begin
            failures++;
            $display("FAIL speed100_rx_rst got=%h exp=%h", rst_v, 24'h00000F);
        end
        checks++;
        if (ce_v !== 24'h084210) begin
            failures++;
            $display("FAIL speed100_clk_enable got=%h exp=%h", ce_v, 24'h084210);
        end
        checks++;
        if ({mii_select, active_speed} !== 3'b1_01) begin
            failures++;
            $display("FAIL speed100_speed got=%b exp=%b", {mii_select, active_speed}, 3'b1_01);
        end
    endtask

    // Frame at 1000M: dv for cycles 0..7, tvalid 3..10 (tlast at 10).
    // Quiet ticks 11..22 bring idle_cnt to 12, BUSY->IDLE lands at 23,
    // the deferred 2->0 switch puts rx_rst up at 24 for four cycles.
    task automatic test_deferred_switch();
        logic [30:0] busy_v, rst_v;
        cfg_speed = 2'd2;
        repeat (12) step();
        for (int k = 0; k < 31; k++) begin
            gmii_rx_dv = (k <= 7);
            rx_tvalid  = (k >= 3) && (k <= 10);
            rx_tlast   = (k == 10);
            cfg_speed  = (k >= 1) ? 2'd0 : 2'd2;
            step();
            busy_v[k] = rx_busy;
            rst_v[k]  = rx_rst;
        end
        gmii_rx_dv = 1'b0;
        rx_tvalid  = 1'b0;
        rx_tlast   = 1'b0;
        checks++;
        if (busy_v !== 31'h007F_FFFF) begin
            failures++;
            $display("FAIL deferred_rx_busy got=%h exp=%h", busy_v, 31'h007F_FFFF);
        end
        checks++;
        if (rst_v !== 31'h0F00_0000) begin
            failures++;
            $display("FAIL deferred_rx_rst got=%h exp=%h", rst_v, 31'h0F00_0000);
        end
        checks++;
        if ({mii_select, active_speed} !== 3'b1_00) begin
            failures++;
            $display("FAIL deferred_speed got=%b exp=%b", {mii_select, active_speed}, 3'b1_00);
        end
    endtask

    task automatic test_statistics();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        checks++;
        if ({stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err} !== 128'd0) begin
            failures++;
            $display("FAIL stats_clear got=%0d %0d %0d %0d exp=0 0 0 0",
                     stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err);
        end
        for (int i = 0; i < 60; i++) begin
            rx_tvalid = 1'b1;
            rx_tlast  = (i == 59);
            step();
        end
        // tlast without tvalid must not count a frame
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b1;
        step();
        for (int i = 0; i < 60; i++) begin
            rx_tvalid = 1'b1;
            rx_tlast  = (i == 59);
            rx_tuser  = (i == 59);
            step();
        end
        rx_tvalid        = 1'b0;
        rx_tlast         = 1'b0;
        rx_tuser         = 1'b0;
        rx_error_bad_fcs = 1'b1;
        step();
        rx_error_bad_fcs = 1'b0;
        step();
        checks++;
        if (stat_bytes !== 32'd120) begin
            failures++;
            $display("FAIL stats_bytes got=%0d exp=120", stat_bytes);
        end
        checks++;
        if ({stat_frames_good, stat_frames_bad, stat_fcs_err} !== {32'd1, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL stats_frames got=%0d %0d %0d exp=1 1 1",
                     stat_frames_good, stat_frames_bad, stat_fcs_err);
        end
        checks++;
        if (stat_bytes_s !== 4'd15) begin
            failures++;
            $display("FAIL stats_bytes_4bit got=%0d exp=15", stat_bytes_s);
        end
    endtask

    task automatic test_saturation_clear();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx_tvalid = 1'b1;
            step();
        end
        rx_tvalid = 1'b0;
        step();
        checks++;
        if (stat_bytes_s !== 4'd15) begin
            failures++;
            $display("FAIL sat_bytes_4bit got=%0d exp=15", stat_bytes_s);
        end
        checks++;
        if (stat_bytes !== 32'd20) begin
            failures++;
            $display("FAIL sat_bytes_32bit got=%0d exp=20", stat_bytes);
        end
        stat_clear = 1'b1;
        rx_tvalid  = 1'b1;
        step();
        stat_clear = 1'b0;
        rx_tvalid  = 1'b0;
        checks++;
        if ({stat_bytes_s, stat_bytes} !== {4'd1, 32'd1}) begin
            failures++;
            $display("FAIL clear_with_event got=%0d %0d exp=1 1", stat_bytes_s, stat_bytes);
        end
        checks++;
        if ({stat_frames_good_s, stat_frames_bad_s, stat_fcs_err_s} !== 12'd0) begin
            failures++;
            $display("FAIL clear_no_event got=%0d %0d %0d exp=0 0 0",
                     stat_frames_good_s, stat_frames_bad_s, stat_fcs_err_s);
        end
    endtask

    task automatic test_async_reset();
        gmii_rx_dv = 1'b1;
        rx_tvalid  = 1'b1;
        step();
        step();
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy got=%b exp=1", rx_busy);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_rst, clk_enable, mii_select, active_speed, rx_busy} !== CTRL_RESET) begin
            failures++;
            $display("FAIL async_reset_ctrl got=%b exp=%b",
                     {rx_rst, clk_enable, mii_select, active_speed, rx_busy}, CTRL_RESET);
        end
        checks++;
        if ({stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err} !== 128'd0) begin
            failures++;
            $display("FAIL async_reset_stats got=%0d %0d %0d %0d exp=0 0 0 0",
                     stat_bytes, stat_frames_good, stat_frames_bad, stat_fcs_err);
        end
        gmii_rx_dv = 1'b0;
        rx_tvalid  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_bringup_1000();
        test_speed_100();
        test_deferred_switch();
        test_statistics();
        test_saturation_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
